mem_responder: RTL

Memory-side responder for the core's load/store interface: accepts one request at a time over a valid/ready handshake, holds it for a fixed access latency, then returns read data or a write acknowledgement over a second valid/ready handshake. Handles byte/half/word lane selection, sign/zero extension, misalignment and out-of-range detection. It sits on the far side of the data (and optionally instruction) port and replaces the zero-latency array model so the core can be exercised against a multi-cycle memory.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_lane_align.sv | 51 +++++
 rtl/mem_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared load/store interface types for the core's memory ports.
package mem_pkg;

  typedef enum logic {
    MEM_OP_READ  = 1'b0,
    MEM_OP_WRITE = 1'b1
  } mem_op_t;

  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'd0,
    MEM_ACCESS_HALF = 2'd1,
    MEM_ACCESS_WORD = 2'd2
  } mem_access_t;

  typedef struct packed {
    mem_op_t     op;
    mem_access_t access_size;
    logic        load_unsigned;
  } mem_params_t;

  typedef enum logic [1:0] {
    MEM_RESP_IDLE = 2'd0,
    MEM_RESP_WAIT = 2'd1,
    MEM_RESP_RESP = 2'd2
  } mem_resp_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sub-word loads and stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  mem_access_t access_size,
  input  logic        load_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] sh_byte;
  logic [31:0] sh_half;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    sh_byte = load_word >> {offset, 3'b000};
    sh_half = load_word >> {offset[1], 4'b0000};
    lane_b  = sh_byte[7:0];
    lane_h  = sh_half[15:0];
  end

  always_comb begin
    byte_en    = 4'hf;
    store_word = store_data;
    load_data  = load_word;
    misaligned = 1'b0;
    case (access_size)
      MEM_ACCESS_BYTE: begin
        byte_en    = 4'b0001 << offset;
        store_word = {4{store_data[7:0]}};
        load_data  = {{24{lane_b[7] & ~load_unsigned}}, lane_b};
      end
      MEM_ACCESS_HALF: begin
        byte_en    = 4'b0011 << {offset[1], 1'b0};
        store_word = {2{store_data[15:0]}};
        load_data  = {{16{lane_h[15] & ~load_unsigned}}, lane_h};
        misaligned = offset[0];
      end
      default: begin
        misaligned = |offset;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder for the core's load/store port.
// Define MEM_RESP_SETUP_EN to add the setup_* preload port.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_address,
  input  logic [31:0] req_data,
  input  mem_params_t req_params,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_error
`ifdef MEM_RESP_SETUP_EN
  ,
  input  logic        setup_write,
  input  logic [31:0] setup_address,
  input  logic [31:0] setup_data_in
`endif
);

  localparam int          IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic        DIRECT = (LATENCY == 1);
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;

  mem_resp_state_t state;
  logic [3:0]      count;
  logic [31:0]     addr_q;
  logic [31:0]     data_q;
  mem_params_t     params_q;

  logic [31:0] storage [DEPTH_WORDS];

  logic        accept;
  logic        fire;
  logic        commit;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  mem_params_t cur_params;
  logic [32:0] offset;
  logic        out_of_range;
  logic        access_err;
  logic [IDX_W-1:0] word_idx;
  logic [31:0] load_word;
  logic [31:0] merged;
  logic [3:0]  byte_en;
  logic [31:0] store_word;
  logic [31:0] load_data;
  logic        misaligned;

  assign req_ready  = (state == MEM_RESP_IDLE) && !reset;
  assign resp_valid = (state == MEM_RESP_RESP);
  assign accept     = req_valid && req_ready;

  // Single-cycle latency performs the access on the accept edge itself,
  // so the live request is used instead of the latched copy.
  assign cur_addr   = (state == MEM_RESP_IDLE) ? req_address : addr_q;
  assign cur_data   = (state == MEM_RESP_IDLE) ? req_data : data_q;
  assign cur_params = (state == MEM_RESP_IDLE) ? req_params : params_q;

  assign fire = ((state == MEM_RESP_WAIT) && (count == 4'd0)) ||
                (DIRECT && accept);

  // Addresses below the base borrow into bit 32 and are rejected too.
  assign offset       = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
  assign out_of_range = offset[32] || (offset >= SPAN);
  assign word_idx     = offset[IDX_W+1:2];
  assign load_word    = storage[word_idx];
  assign access_err   = misaligned || out_of_range;

  assign commit = fire && (cur_params.op == MEM_OP_WRITE) && !access_err;

  mem_lane_align u_align (
    .offset        (cur_addr[1:0]),
    .access_size   (cur_params.access_size),
    .load_unsigned (cur_params.load_unsigned),
    .store_data    (cur_data),
    .load_word     (load_word),
    .byte_en       (byte_en),
    .store_word    (store_word),
    .load_data     (load_data),
    .misaligned    (misaligned)
  );

  always_comb begin
    merged = load_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) merged[8*i +: 8] = store_word[8*i +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= MEM_RESP_IDLE;
      count      <= 4'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      params_q   <= '0;
      resp_data  <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      if (fire) begin
        resp_error <= access_err;
        if (access_err || cur_params.op == MEM_OP_WRITE)
          resp_data <= 32'd0;
        else
          resp_data <= load_data;
      end
      unique case (state)
        MEM_RESP_IDLE: begin
          if (accept) begin
            addr_q   <= req_address;
            data_q   <= req_data;
            params_q <= req_params;
            count    <= LAT_M1;
            state    <= DIRECT ? MEM_RESP_RESP : MEM_RESP_WAIT;
          end
        end
        MEM_RESP_WAIT: begin
          if (count == 4'd0) state <= MEM_RESP_RESP;
          else count <= count - 4'd1;
        end
        MEM_RESP_RESP: begin
          if (resp_ready) state <= MEM_RESP_IDLE;
        end
        default: state <= MEM_RESP_IDLE;
      endcase
    end
  end

`ifdef MEM_RESP_SETUP_EN
  logic [32:0]      setup_off;
  logic [IDX_W-1:0] setup_idx;
  logic             setup_hit;

  assign setup_off = {1'b0, setup_address} - {1'b0, BASE_ADDR};
  assign setup_idx = setup_off[IDX_W+1:2];
  assign setup_hit = setup_write && !setup_off[32] && (setup_off < SPAN);

  // Setup is assigned last so it wins a same-word collision.
  always_ff @(posedge clock) begin
    if (commit) storage[word_idx] <= merged;
    if (setup_hit) storage[setup_idx] <= setup_data_in;
  end
`else
  always_ff @(posedge clock) begin
    if (commit) storage[word_idx] <= merged;
  end
`endif

endmodule
